// File: rtl/print_sequencer_pkg.sv
// Shared types and constants for the print sequencer.
// PRINT_SEQ_CLEAR_EN adds the clear-screen state and its byte ROM.
package print_sequencer_pkg;

  localparam int BOARD_W_DEF = 320;
  localparam int SCORE_W_DEF = 21;

  localparam logic [7:0] ASCII_ESC  = 8'h1B;
  localparam logic [7:0] ASCII_LBRK = 8'h5B;
  localparam logic [7:0] ASCII_2    = 8'h32;
  localparam logic [7:0] ASCII_J    = 8'h4A;
  localparam logic [7:0] ASCII_H    = 8'h48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_START,
    S_ARM,
    S_ISSUE,
    S_CAPT,
    S_SEND
`ifdef PRINT_SEQ_CLEAR_EN
    , S_CLR
`endif
  } state_e;

`ifdef PRINT_SEQ_CLEAR_EN
  localparam int CLR_LEN = 7;

  // ESC [ 2 J ESC [ H
  function automatic logic [7:0] clr_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0, 3'd4: b = ASCII_ESC;
      3'd1, 3'd5: b = ASCII_LBRK;
      3'd2:       b = ASCII_2;
      3'd3:       b = ASCII_J;
      default:    b = ASCII_H;
    endcase
    return b;
  endfunction
`endif

endpackage

// File: rtl/print_sequencer_tx_hold.sv
// One-byte valid/ready holding register feeding the UART TX.
// A load may coincide with the acceptance of the previous byte.
module tx_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/print_sequencer.sv
// Print sequencer: snapshots board/score, steps the printer, forwards chars to UART.
// Define PRINT_SEQ_CLEAR_EN to send an ANSI clear-screen before each frame.
module print_sequencer
  import print_sequencer_pkg::*;
#(
  parameter int BOARD_W   = BOARD_W_DEF,
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int MAX_CHARS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [SCORE_W-1:0] score_in,
  output logic [BOARD_W-1:0] prn_board,
  output logic [SCORE_W-1:0] prn_score,
  output logic               prn_start,
  output logic               prn_next,
  input  logic [7:0]         prn_char,
  input  logic               prn_done,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               err,
  output logic [15:0]        char_cnt
);

  localparam logic [15:0] MaxCnt = 16'(MAX_CHARS);

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic               ph_q, ph_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               hold_load;
  logic [7:0]         hold_din;
`ifdef PRINT_SEQ_CLEAR_EN
  logic [2:0]         clr_q, clr_d;
`endif

  tx_hold u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hold_load),
    .data_i  (hold_din),
    .ready_i (tx_ready),
    .valid_o (tx_valid),
    .data_o  (tx_data)
  );

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    score_d   = score_q;
    pend_d    = pend_q;
    err_d     = err_q;
    ph_d      = 1'b0;
    cnt_d     = cnt_q;
    hold_load = 1'b0;
    hold_din  = prn_char;
    prn_start = 1'b0;
    prn_next  = 1'b0;
`ifdef PRINT_SEQ_CLEAR_EN
    clr_d     = clr_q;
`endif

    // requests while busy coalesce into one follow-up frame
    if (req && state_q != S_IDLE) pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (!prn_done) begin
          pend_d  = pend_q | req;
          state_d = S_DRAIN;
        end else if (req || pend_q) begin
          board_d = board_in;
          score_d = score_in;
          pend_d  = 1'b0;
          cnt_d   = 16'd0;
`ifdef PRINT_SEQ_CLEAR_EN
          hold_load = 1'b1;
          hold_din  = clr_byte(3'd0);
          clr_d     = 3'd1;
          state_d   = S_CLR;
`else
          state_d   = S_START;
`endif
        end
      end
      S_DRAIN: begin
        if (prn_done) begin
          state_d = S_IDLE;
        end else begin
          prn_next = !ph_q;
          ph_d     = !ph_q;
        end
      end
`ifdef PRINT_SEQ_CLEAR_EN
      S_CLR: begin
        if (tx_valid && tx_ready) begin
          if (clr_q == 3'(CLR_LEN)) begin
            state_d = S_START;
          end else begin
            hold_load = 1'b1;
            hold_din  = clr_byte(clr_q);
            clr_d     = clr_q + 3'd1;
          end
        end
      end
`endif
      S_START: begin
        prn_start = 1'b1;
        state_d   = S_ARM;
      end
      S_ARM: begin
        if (!prn_done) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        prn_next = 1'b1;
        state_d  = S_CAPT;
      end
      S_CAPT: begin
        if (prn_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == MaxCnt) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else begin
          hold_load = 1'b1;
          cnt_d     = cnt_q + 16'd1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_valid && tx_ready) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      board_q <= '0;
      score_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      ph_q    <= 1'b0;
      cnt_q   <= 16'd0;
`ifdef PRINT_SEQ_CLEAR_EN
      clr_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      score_q <= score_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
`ifdef PRINT_SEQ_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  assign prn_board = board_q;
  assign prn_score = score_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign char_cnt  = cnt_q;

endmodule
